// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the Sher-VI ALU issue sequencer and anything that
// talks to the ALU on its behalf.
//   seqState_e : sequencer control states (IDLE, SETTLE, RESP)
//   F3_*       : ALU operation codes carried on funct3
//   CMP_*      : compare codes, decoded by the ALU from funct3[1:0] only
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } seqState_e;

   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_SUB = 3'd1;
   localparam logic [2:0] F3_XOR = 3'd2;
   localparam logic [2:0] F3_OR  = 3'd3;
   localparam logic [2:0] F3_AND = 3'd4;
   localparam logic [2:0] F3_SLL = 3'd5;
   localparam logic [2:0] F3_SRL = 3'd6;
   localparam logic [2:0] F3_SRA = 3'd7;

   localparam logic [1:0] CMP_EQ = 2'd0;
   localparam logic [1:0] CMP_NE = 2'd1;
   localparam logic [1:0] CMP_LT = 2'd2;
   localparam logic [1:0] CMP_GE = 2'd3;

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle issue controller in front of the combinational Sher-VI ALU.
// A request is accepted over a valid/ready handshake, its operands are
// registered onto the ALU inputs and held for SETTLE_CYCLES cycles, then the
// ALU result is captured and offered over a second valid/ready handshake.
//
// Ports
//   CLK, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_funct3            : ALU opcode / compare code
//   req_is_cmp            : result is the zero-extended compare bit
//   req_a, req_b          : operands
//   alu_funct3/alu_a/alu_b: registered drive into the ALU
//   alu_out, alu_cmp      : combinational ALU results
//   rsp_valid/rsp_ready   : response handshake (valid only in RESP)
//   rsp_data, rsp_cmp     : captured result and compare bit
//   busy                  : an operation is in flight or awaiting pickup
//   op_count              : completed responses, modulo 256
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic             req_is_cmp,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [2:0]       alu_funct3,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cmp,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_cmp,
   output logic             busy,
   output logic [7:0]       op_count
);

   // The counter counts down to zero, so loading SETTLE_CYCLES-1 yields
   // exactly SETTLE_CYCLES edges between acceptance and capture.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   seqState_e        state_q, state_d;
   logic [3:0]       settleCnt_q, settleCnt_d;
   logic [2:0]       aluFunct3_q, aluFunct3_d;
   logic [WIDTH-1:0] aluA_q, aluA_d;
   logic [WIDTH-1:0] aluB_q, aluB_d;
   logic             isCmp_q, isCmp_d;
   logic [WIDTH-1:0] rspData_q, rspData_d;
   logic             rspCmp_q, rspCmp_d;
   logic [7:0]       opCount_q, opCount_d;

   // State and datapath registers. Reset drops any in-flight operation
   // without producing a response.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         settleCnt_q <= '0;
         aluFunct3_q <= '0;
         aluA_q      <= '0;
         aluB_q      <= '0;
         isCmp_q     <= 1'b0;
         rspData_q   <= '0;
         rspCmp_q    <= 1'b0;
         opCount_q   <= '0;
      end else begin
         state_q     <= state_d;
         settleCnt_q <= settleCnt_d;
         aluFunct3_q <= aluFunct3_d;
         aluA_q      <= aluA_d;
         aluB_q      <= aluB_d;
         isCmp_q     <= isCmp_d;
         rspData_q   <= rspData_d;
         rspCmp_q    <= rspCmp_d;
         opCount_q   <= opCount_d;
      end
   end

   // Next-state logic. Everything holds by default; the ALU operand
   // registers only move when a request is accepted in IDLE, so the ALU
   // inputs stay stable through SETTLE and RESP.
   always_comb begin
      state_d     = state_q;
      settleCnt_d = settleCnt_q;
      aluFunct3_d = aluFunct3_q;
      aluA_d      = aluA_q;
      aluB_d      = aluB_q;
      isCmp_d     = isCmp_q;
      rspData_d   = rspData_q;
      rspCmp_d    = rspCmp_q;
      opCount_d   = opCount_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               aluFunct3_d = req_funct3;
               aluA_d      = req_a;
               aluB_d      = req_b;
               isCmp_d     = req_is_cmp;
               settleCnt_d = SETTLE_LOAD;
               state_d     = SETTLE;
            end
         end
         SETTLE: begin
            if (settleCnt_q == 4'd0) begin
               rspData_d = isCmp_q ? {{(WIDTH-1){1'b0}}, alu_cmp} : alu_out;
               rspCmp_d  = alu_cmp;
               state_d   = RESP;
            end else begin
               settleCnt_d = settleCnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               opCount_d = opCount_q + 8'd1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake flags come straight from the state register so neither
   // ready nor valid depends combinationally on the other side.
   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign alu_funct3 = aluFunct3_q;
   assign alu_a      = aluA_q;
   assign alu_b      = aluB_q;
   assign rsp_data   = rspData_q;
   assign rsp_cmp    = rspCmp_q;
   assign op_count   = opCount_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer. A behavioural ALU stands in for
// the real one, a transaction-level model predicts every output each cycle,
// and directed operations with hand-computed results pin the model.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int WIDTH  = 16;
   localparam int SETTLE = 2;

   logic             CLK = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_funct3;
   logic             req_is_cmp;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       alu_funct3;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_cmp;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_cmp;
   logic             busy;
   logic [7:0]       op_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
      .CLK(CLK), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_is_cmp(req_is_cmp),
      .req_a(req_a), .req_b(req_b),
      .alu_funct3(alu_funct3), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_cmp(alu_cmp),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_cmp(rsp_cmp),
      .busy(busy), .op_count(op_count)
   );

   always #5 CLK = ~CLK;

   // Reference ALU arithmetic, used both for the stand-in ALU and the model.
   function automatic logic [WIDTH-1:0] aluRef(input logic [2:0] f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (f)
         F3_ADD:  r = a + b;
         F3_SUB:  r = a - b;
         F3_XOR:  r = a ^ b;
         F3_OR:   r = a | b;
         F3_AND:  r = a & b;
         F3_SLL:  r = a << b[3:0];
         F3_SRL:  r = a >> b[3:0];
         default: r = WIDTH'($signed(a) >>> b[3:0]);
      endcase
      return r;
   endfunction

   function automatic logic cmpRef(input logic [2:0] f,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
      logic r;
      case (f[1:0])
         CMP_EQ:  r = (a == b);
         CMP_NE:  r = (a != b);
         CMP_LT:  r = ($signed(a) <  $signed(b));
         default: r = ($signed(a) >= $signed(b));
      endcase
      return r;
   endfunction

   // Stand-in for the ALU instance that sits beside the sequencer.
   assign alu_out = aluRef(alu_funct3, alu_a, alu_b);
   assign alu_cmp = cmpRef(alu_funct3, alu_a, alu_b);

   // Transaction-level model: an accepted operation becomes a response a
   // fixed number of edges later and is retired by the consumer handshake.
   int               mEdge;
   int               mAcceptEdge;
   bit               mInFlight;
   bit               mRespOn;
   logic [2:0]       mF;
   logic [WIDTH-1:0] mA, mB, mData;
   logic             mIsCmp, mCmp;
   logic [7:0]       mCount;

   always @(posedge CLK) begin
      cyc   = cyc + 1;
      mEdge = mEdge + 1;
      if (reset) begin
         mInFlight = 0; mRespOn = 0;
         mF = '0; mA = '0; mB = '0; mIsCmp = 0;
         mData = '0; mCmp = 0; mCount = '0;
      end else if (mRespOn) begin
         if (rsp_ready) begin
            mRespOn = 0;
            mCount  = mCount + 8'd1;
         end
      end else if (mInFlight) begin
         if (mEdge == mAcceptEdge + SETTLE) begin
            mInFlight = 0;
            mRespOn   = 1;
            mCmp      = cmpRef(mF, mA, mB);
            mData     = mIsCmp ? WIDTH'(mCmp) : aluRef(mF, mA, mB);
         end
      end else if (req_valid) begin
         mInFlight   = 1;
         mAcceptEdge = mEdge;
         mF = req_funct3; mA = req_a; mB = req_b; mIsCmp = req_is_cmp;
      end
   end

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one request, wait for its response and check it against the
   // hand-computed values. Returns after the handshake when rsp_ready is 1.
   task automatic applyStimulus(input logic [2:0] f, input logic c,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] expData, input logic expCmp,
                                input string name);
      int k;
      @(negedge CLK);
      req_valid = 1'b1; req_funct3 = f; req_is_cmp = c; req_a = a; req_b = b;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge CLK);
         k++;
      end
      checkOutput({name, " accept"}, WIDTH'(req_ready), WIDTH'(1));
      @(negedge CLK);
      req_valid = 1'b0;
      k = 1;
      while (!rsp_valid && k < 20) begin
         @(negedge CLK);
         k++;
      end
      checkOutput({name, " edges to rsp_valid"}, WIDTH'(k - 1), WIDTH'(SETTLE));
      checkOutput({name, " rsp_data"}, rsp_data, expData);
      checkOutput({name, " rsp_cmp"}, WIDTH'(rsp_cmp), WIDTH'(expCmp));
      if (rsp_ready) @(negedge CLK);
   endtask

   initial begin
      int k;
      int prevAccept;
      reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_is_cmp = 1'b0;
      req_a = '0; req_b = '0; rsp_ready = 1'b1;
      mEdge = 0; mAcceptEdge = 0;
      repeat (2) @(negedge CLK);
      reset = 1'b0;

      // Cycle-by-cycle comparison of every output against the model.
      fork
         forever begin
            @(negedge CLK);
            checkOutput("req_ready",  WIDTH'(req_ready), WIDTH'(!mInFlight && !mRespOn));
            checkOutput("rsp_valid",  WIDTH'(rsp_valid), WIDTH'(mRespOn));
            checkOutput("busy",       WIDTH'(busy),      WIDTH'(mInFlight || mRespOn));
            checkOutput("rsp_data",   rsp_data,          mData);
            checkOutput("rsp_cmp",    WIDTH'(rsp_cmp),   WIDTH'(mCmp));
            checkOutput("alu_funct3", WIDTH'(alu_funct3), WIDTH'(mF));
            checkOutput("alu_a",      alu_a,             mA);
            checkOutput("alu_b",      alu_b,             mB);
            checkOutput("op_count",   WIDTH'(op_count),  WIDTH'(mCount));
         end
      join_none

      // Reset for one cycle in the middle of SETTLE.
      @(negedge CLK);
      req_valid = 1'b1; req_funct3 = F3_ADD; req_is_cmp = 1'b0; req_a = 16'd4; req_b = 16'd5;
      @(negedge CLK);
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      checkOutput("rst req_ready", WIDTH'(req_ready), 16'd1);
      checkOutput("rst rsp_valid", WIDTH'(rsp_valid), 16'd0);
      checkOutput("rst rsp_data",  rsp_data, 16'd0);
      checkOutput("rst rsp_cmp",   WIDTH'(rsp_cmp), 16'd0);
      checkOutput("rst alu_funct3", WIDTH'(alu_funct3), 16'd0);
      checkOutput("rst alu_a",     alu_a, 16'd0);
      checkOutput("rst alu_b",     alu_b, 16'd0);
      checkOutput("rst busy",      WIDTH'(busy), 16'd0);
      checkOutput("rst op_count",  WIDTH'(op_count), 16'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("no rsp after reset", WIDTH'(rsp_valid), 16'd0);
      end

      // Directed operations with hand-computed results.
      applyStimulus(F3_ADD, 1'b0, 16'd4, 16'd5, 16'd9, 1'b0, "add 4+5");
      checkOutput("op_count after add", WIDTH'(op_count), 16'd1);
      applyStimulus(F3_SRA, 1'b0, 16'hF830, 16'd1, 16'hFC18, 1'b0, "sra -2000>>>1");
      applyStimulus(F3_SUB, 1'b0, 16'd10, 16'd4, 16'd6, 1'b1, "sub 10-4");
      applyStimulus(F3_AND, 1'b0, 16'd11, 16'd5, 16'd1, 1'b0, "and 11&5");
      applyStimulus(F3_SLL, 1'b0, 16'd3, 16'd2, 16'd12, 1'b1, "sll 3<<2");
      applyStimulus(3'd0, 1'b1, 16'd1, 16'd1, 16'd1, 1'b1, "cmp eq 1,1");
      applyStimulus(3'd6, 1'b1, 16'd3, 16'd1, 16'd0, 1'b0, "cmp lt 3,1");
      applyStimulus(3'd7, 1'b1, 16'd0, 16'd1, 16'd0, 1'b0, "cmp ge 0,1");

      // Backpressure: response held for 5 cycles, new request ignored.
      rsp_ready = 1'b0;
      applyStimulus(F3_XOR, 1'b0, 16'h00F0, 16'h0FF0, 16'h0F00, 1'b1, "xor held");
      req_valid = 1'b1; req_funct3 = F3_OR; req_a = 16'h1234; req_b = 16'h4321;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("held rsp_valid", WIDTH'(rsp_valid), 16'd1);
         checkOutput("held rsp_data",  rsp_data, 16'h0F00);
         checkOutput("held req_ready", WIDTH'(req_ready), 16'd0);
         checkOutput("held alu_a",     alu_a, 16'h00F0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge CLK);
      checkOutput("release req_ready", WIDTH'(req_ready), 16'd1);
      checkOutput("release op_count",  WIDTH'(op_count), 16'd9);

      // 256 back-to-back operations from a fresh reset: op_count wraps.
      @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      req_valid = 1'b1;
      prevAccept = 0;
      for (int i = 0; i < 256; i++) begin
         req_funct3 = 3'(i);
         req_is_cmp = i[3];
         req_a      = 16'(i * 7);
         req_b      = 16'(i % 16);
         k = 0;
         while (!req_ready && k < 20) begin
            @(negedge CLK);
            k++;
         end
         checkOutput("b2b accept", WIDTH'(req_ready), 16'd1);
         if (i == 255) checkOutput("op_count at 255", WIDTH'(op_count), 16'd255);
         if (i > 0) checkOutput("issue interval", WIDTH'(cyc - prevAccept), WIDTH'(SETTLE + 2));
         prevAccept = cyc;
         @(negedge CLK);
      end
      req_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 20) begin
         @(negedge CLK);
         k++;
      end
      @(negedge CLK);
      checkOutput("op_count wrap", WIDTH'(op_count), 16'd0);
      repeat (2) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
